sr_reg_bank: RTL and testbench

//   Parametrised bank of WIDTH clocked set/reset flip-flops, one per channel, with a Q/Qn pair per channel.

---
 rtl/sr_reg_bank.sv | 108 ++++++++++
 tb/tb_sr_reg_bank.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sr_reg_bank.sv
// Bank of WIDTH clocked set/reset flip-flops with a saturating conflict counter.
// Optional sticky per-channel conflict flags when SR_BANK_STICKY_EN is defined.

module sr_reg_bank_lane #(
    parameter int   CONFLICT_MODE = 0,
    parameter logic INIT          = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_s,
    input  logic i_r,
    output logic o_q
);
    logic r_q;
    logic w_nxt;

    always_comb begin
        w_nxt = r_q;
        case ({i_s, i_r})
            2'b10: w_nxt = 1'b1;
            2'b01: w_nxt = 1'b0;
            2'b11: begin
                case (CONFLICT_MODE)
                    1:       w_nxt = 1'b1;
                    2:       w_nxt = 1'b0;
                    3:       w_nxt = ~r_q;
                    default: w_nxt = r_q;
                endcase
            end
            default: w_nxt = r_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_q <= INIT;
        else if (i_en) r_q <= w_nxt;
    end

    assign o_q = r_q;
endmodule

module sr_reg_bank #(
    parameter int               WIDTH         = 8,
    parameter int               CONFLICT_MODE = 0,
    parameter logic [WIDTH-1:0] INIT          = '0,
    parameter int               CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic [CNT_W-1:0] conflict_cnt
`ifdef SR_BANK_STICKY_EN
    ,
    output logic [WIDTH-1:0] conflict_flag
`endif
);
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_conf;
    logic [CNT_W-1:0] r_cnt;

    assign w_conf = S & R;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        sr_reg_bank_lane #(
            .CONFLICT_MODE(CONFLICT_MODE),
            .INIT         (INIT[i])
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .i_en(en),
            .i_s (S[i]),
            .i_r (R[i]),
            .o_q (w_q[i])
        );
    end

    // One count per conflicting cycle regardless of how many channels collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (cnt_clr)
            r_cnt <= '0;
        else if (en && (|w_conf) && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

`ifdef SR_BANK_STICKY_EN
    logic [WIDTH-1:0] r_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_flag <= '0;
        else if (cnt_clr) r_flag <= '0;
        else if (en)      r_flag <= r_flag | w_conf;
    end

    assign conflict_flag = r_flag;
`endif

    assign Q            = w_q;
    assign Qn           = ~w_q;
    assign conflict_cnt = r_cnt;
endmodule

// File: tb/tb_sr_reg_bank.sv
// Scoreboard bench for sr_reg_bank: four instances, one per CONFLICT_MODE, share stimulus.
// Honours SR_BANK_STICKY_EN for the conflict_flag checks.

module tb_sr_reg_bank;
    localparam logic [7:0] INIT = 8'hA5;

    typedef struct packed {
        logic [3:0][7:0] q;
        logic [3:0][3:0] cnt;
        logic [7:0]      flag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] S, R;
    logic       cnt_clr;
    logic [7:0] q   [4];
    logic [7:0] qn  [4];
    logic [3:0] cnt [4];
`ifdef SR_BANK_STICKY_EN
    logic [7:0] flag[4];
`endif

    int checks   = 0;
    int failures = 0;

    exp_t       exp_q[$];
    logic [7:0] m_q[4];
    int         m_cnt;
    logic [7:0] m_flag;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        sr_reg_bank #(
            .WIDTH(8), .CONFLICT_MODE(m), .INIT(INIT), .CNT_W(4)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .en          (en),
            .S           (S),
            .R           (R),
            .cnt_clr     (cnt_clr),
            .Q           (q[m]),
            .Qn          (qn[m]),
            .conflict_cnt(cnt[m])
`ifdef SR_BANK_STICKY_EN
            ,
            .conflict_flag(flag[m])
`endif
        );
    end

    task automatic chk(input string name, input int m, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s mode=%0d got=%h expected=%h t=%0t", name, m, got, want, $time);
        end
    endtask

    task automatic chk_all(input string name, input exp_t e);
        for (int m = 0; m < 4; m++) begin
            chk({name, "_q"},   m, q[m],           e.q[m]);
            chk({name, "_qn"},  m, qn[m],          ~e.q[m]);
            chk({name, "_cnt"}, m, {4'h0, cnt[m]}, {4'h0, e.cnt[m]});
`ifdef SR_BANK_STICKY_EN
            chk({name, "_flag"}, m, flag[m], e.flag);
`endif
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        for (int m = 0; m < 4; m++) begin
            e.q[m]   = m_q[m];
            e.cnt[m] = 4'(m_cnt);
        end
        e.flag = m_flag;
        return e;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 4; m++) m_q[m] = INIT;
        m_cnt  = 0;
        m_flag = 8'h00;
    endtask

    // Drive one cycle of stimulus and push the state expected after the next edge.
    task automatic drive(input logic e, input logic [7:0] s, input logic [7:0] r, input logic c);
        logic [7:0] conf;
        @(negedge clk);
        en = e; S = s; R = r; cnt_clr = c;
        conf = s & r;
        if (e) begin
            for (int m = 0; m < 4; m++) begin
                logic [7:0] nq;
                nq = (m_q[m] | (s & ~r)) & ~(r & ~s);
                case (m)
                    1: nq = nq | conf;
                    2: nq = nq & ~conf;
                    3: nq = nq ^ conf;
                    default: ;
                endcase
                m_q[m] = nq;
            end
        end
        if (c)                      m_cnt = 0;
        else if (e && conf != 8'h0) m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
        if (c)      m_flag = 8'h00;
        else if (e) m_flag = m_flag | conf;
        exp_q.push_back(snapshot());
    endtask

    // Let the monitor consume everything queued so far.
    task automatic drain();
        @(negedge clk);
        en = 1'b0; cnt_clr = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_all("cycle", e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; S = '0; R = '0; cnt_clr = 1'b0;
        model_reset();
        #12;
        chk_all("in_reset", snapshot());
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all("post_release", snapshot());

        // Clear, then set low nibble, then reset bits 1:0.
        drive(1, 8'h00, 8'hFF, 0);
        drive(1, 8'h0F, 8'h00, 0);
        drive(1, 8'h00, 8'h03, 0);
        // Disabled: nothing moves, no conflict counted.
        drive(0, 8'hFF, 8'h00, 0);
        drive(0, 8'h01, 8'h01, 0);
        // Conflict on bit 0 for several cycles: mode-specific behaviour.
        repeat (4) drive(1, 8'h01, 8'h01, 0);
        // Saturation, then clear beats a simultaneous increment.
        repeat (20) drive(1, 8'h80, 8'h80, 0);
        drive(1, 8'h80, 8'h80, 1);
        drive(1, 8'h00, 8'h00, 0);
        // Sticky flags survive S/R dropping, then cleared.
        drive(1, 8'h24, 8'h24, 0);
        drive(1, 8'h00, 8'h00, 0);
        drive(1, 8'h00, 8'h00, 0);
        drive(0, 8'h00, 8'h00, 1);
        // cnt_clr leaves Q alone.
        drive(1, 8'hFF, 8'h00, 0);
        drive(1, 8'h00, 8'h00, 1);
        drain();

        // Asynchronous reset between edges.
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk_all("async_rst", snapshot());
        @(posedge clk);
        #1;
        chk_all("rst_held", snapshot());
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            logic [7:0] s, r;
            s = 8'($urandom);
            r = 8'($urandom);
            if ($urandom_range(1, 0) == 0) r = r & ~s;
            if ($urandom_range(3, 0) == 0) r = r & 8'h0F;
            drive(($urandom_range(3, 0) != 0), s, r, ($urandom_range(15, 0) == 0));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
